// File: rtl/peripheral_msi_rr_watchdog_arbiter_wb.sv
// Round-robin Wishbone arbiter sharing one slave port between NUM_MASTERS masters.
// Grant is held for the whole cyc; a watchdog aborts a silent slave with err to the owner.
module peripheral_msi_rr_watchdog_arbiter_wb #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]     wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int SW  = DW / 8;
  localparam int IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ABORT} state_e;

  state_e                  state_q;
  logic [IW-1:0]           owner_q, last_q;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic [WDW-1:0]          wdog_q, wdog_d;
  logic                    wdog_hit;
  logic [IW-1:0]           pick_idx, cand;
  logic                    pick_valid;
  logic                    owner_cyc, owner_stb, in_grant, in_abort, resp;

  assign owner_cyc = wbm_cyc_i[owner_q];
  assign owner_stb = wbm_stb_i[owner_q];
  assign in_grant  = (state_q == S_GRANT);
  assign in_abort  = (state_q == S_ABORT);
  assign resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign wbs_cyc_o = in_grant & owner_cyc;
  assign wbs_stb_o = in_grant & owner_stb;
  assign grant_o   = grant_q;
  assign timeout_o = in_abort;
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

  assign wbm_ack_o = in_grant ? (grant_q & {NUM_MASTERS{wbs_ack_i}}) : '0;
  assign wbm_rty_o = in_grant ? (grant_q & {NUM_MASTERS{wbs_rty_i}}) : '0;
  assign wbm_err_o = in_grant ? (grant_q & {NUM_MASTERS{wbs_err_i}}) :
                     in_abort ? grant_q : '0;

  // Descending scan so the last hit is the closest requester after last_q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IW'((int'(last_q) + i) % NUM_MASTERS);
      if (wbm_cyc_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    wbs_adr_o = wbm_adr_i[AW-1:0];
    wbs_dat_o = wbm_dat_i[DW-1:0];
    wbs_sel_o = wbm_sel_i[SW-1:0];
    wbs_we_o  = wbm_we_i[0];
    wbs_cti_o = wbm_cti_i[2:0];
    wbs_bte_o = wbm_bte_i[1:0];
    for (int k = 1; k < NUM_MASTERS; k++) begin
      if (owner_q == IW'(k)) begin
        wbs_adr_o = wbm_adr_i[k*AW +: AW];
        wbs_dat_o = wbm_dat_i[k*DW +: DW];
        wbs_sel_o = wbm_sel_i[k*SW +: SW];
        wbs_we_o  = wbm_we_i[k];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
      end
    end
  end

  // Saturating watchdog; hit means the counter reaches TIMEOUT this cycle.
  always_comb begin
    wdog_d   = '0;
    wdog_hit = 1'b0;
    if (TIMEOUT > 0 && wbs_stb_o && !resp) begin
      wdog_d   = (wdog_q == WDW'(TIMEOUT)) ? wdog_q : wdog_q + WDW'(1);
      wdog_hit = (wdog_d == WDW'(TIMEOUT));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      wdog_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wdog_q <= '0;
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!owner_cyc) begin
            last_q  <= owner_q;
            owner_q <= '0;
            grant_q <= '0;
            wdog_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            wdog_q <= wdog_d;
            if (wdog_hit) state_q <= S_ABORT;
          end
        end
        S_ABORT: begin
          last_q  <= owner_q;
          owner_q <= '0;
          grant_q <= '0;
          wdog_q  <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
